// File: rtl/cascade_up_counter.sv
// Cascadable registered up-counter slice with parallel load, synchronous clear,
// enp/ent two-level enable, ripple carry out and a one-shot start/done/ack mode.
module cascade_up_counter #(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             enp,
    input  logic             ent,
    input  logic             oneshot,
    input  logic             start,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_plus;
    logic             wrap_nxt;
    logic             at_max;
    logic             inc;

    assign at_max = (q == MAX_Q);
    assign q_plus = q + WIDTH'(1);
    // One-shot never counts past MAX_VAL, so the RUN qualifier also stops at terminal count.
    assign inc    = enp & ent & (oneshot ? ((state == RUN) & ~at_max) : 1'b1);

    assign rco  = at_max & ent;
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        q_nxt     = q;
        wrap_nxt  = 1'b0;
        state_nxt = state;
        if (sclr) begin
            q_nxt     = '0;
            state_nxt = IDLE;
        end else begin
            if (load) begin
                q_nxt = din;
            end else if (inc) begin
                if (at_max) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q_plus;
                end
            end

            if (!oneshot) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        // A start coinciding with a load judges terminal count on the loaded value.
                        if (start) begin
                            state_nxt = (load ? (din == MAX_Q) : at_max) ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        if (load ? (din == MAX_Q) : (at_max | (inc & (q_plus == MAX_Q)))) begin
                            state_nxt = DONE;
                        end
                    end
                    DONE: begin
                        if (ack) begin
                            state_nxt = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            wrap  <= 1'b0;
            state <= IDLE;
        end else begin
            q     <= q_nxt;
            wrap  <= wrap_nxt;
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_cascade_up_counter.sv
// Directed bench for cascade_up_counter: free-run, priority, two-slice cascade,
// one-shot handshake, abort paths and out-of-range load.
module tb_cascade_up_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // slice 0 / slice 1: cascaded pair, MAX_VAL = 15
    logic       sclr0, load0, enp0, ent0, os0, start0, ack0;
    logic [3:0] din0, q0;
    logic       rco0, wrap0, busy0, done0;
    logic       sclr1, load1, enp1, os1, start1, ack1;
    logic [3:0] din1, q1;
    logic       rco1, wrap1, busy1, done1;
    // one-shot slice, MAX_VAL = 5
    logic       sclr_o, load_o, enp_o, ent_o, os_o, start_o, ack_o;
    logic [3:0] din_o, q_o;
    logic       rco_o, wrap_o, busy_o, done_o;
    // out-of-range slice, MAX_VAL = 9
    logic       sclr_m, load_m, enp_m, ent_m, os_m, start_m, ack_m;
    logic [3:0] din_m, q_m;
    logic       rco_m, wrap_m, busy_m, done_m;

    cascade_up_counter #(.WIDTH(4), .MAX_VAL(15)) u_slice0 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr0), .load(load0), .din(din0), .enp(enp0),
        .ent(ent0), .oneshot(os0), .start(start0), .ack(ack0), .q(q0), .rco(rco0),
        .wrap(wrap0), .busy(busy0), .done(done0));

    cascade_up_counter #(.WIDTH(4), .MAX_VAL(15)) u_slice1 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr1), .load(load1), .din(din1), .enp(enp1),
        .ent(rco0), .oneshot(os1), .start(start1), .ack(ack1), .q(q1), .rco(rco1),
        .wrap(wrap1), .busy(busy1), .done(done1));

    cascade_up_counter #(.WIDTH(4), .MAX_VAL(5)) u_oneshot (
        .clk(clk), .rst_n(rst_n), .sclr(sclr_o), .load(load_o), .din(din_o), .enp(enp_o),
        .ent(ent_o), .oneshot(os_o), .start(start_o), .ack(ack_o), .q(q_o), .rco(rco_o),
        .wrap(wrap_o), .busy(busy_o), .done(done_o));

    cascade_up_counter #(.WIDTH(4), .MAX_VAL(9)) u_mod9 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr_m), .load(load_m), .din(din_m), .enp(enp_m),
        .ent(ent_m), .oneshot(os_m), .start(start_m), .ack(ack_m), .q(q_m), .rco(rco_m),
        .wrap(wrap_m), .busy(busy_m), .done(done_m));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int seq_m9[12] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

    initial begin
        rst_n = 1'b0;
        {sclr0, load0, enp0, os0, start0, ack0, din0} = '0; ent0 = 1'b1;
        {sclr1, load1, enp1, os1, start1, ack1, din1} = '0;
        {sclr_o, load_o, enp_o, os_o, start_o, ack_o, din_o} = '0; ent_o = 1'b1;
        {sclr_m, load_m, enp_m, os_m, start_m, ack_m, din_m} = '0; ent_m = 1'b1;
        #3;
        check("reset_q", q0, 0);
        check("reset_wrap", wrap0, 0);
        check("reset_rco", rco0, 0);
        check("reset_busy_done", {busy_o, done_o}, 0);
        tick();
        rst_n = 1'b1;

        // free-run over 17 edges
        enp0 = 1'b1;
        for (int i = 0; i <= 17; i++) begin
            check($sformatf("free_q_%0d", i), q0, i % 16);
            check($sformatf("free_rco_%0d", i), rco0, (i % 16) == 15);
            check($sformatf("free_wrap_%0d", i), wrap0, i == 16);
            tick();
        end

        // priority: sclr over load, load over inc, hold
        load0 = 1'b1; din0 = 4'd7;
        tick();
        check("prio_load7", q0, 7);
        din0 = 4'd3; sclr0 = 1'b1;
        tick();
        check("prio_sclr", q0, 0);
        sclr0 = 1'b0;
        tick();
        check("prio_load_no_inc", q0, 3);
        load0 = 1'b0; enp0 = 1'b0;
        tick();
        tick();
        check("prio_hold_q", q0, 3);
        check("prio_hold_wrap", wrap0, 0);

        // two-slice cascade
        load0 = 1'b1; din0 = 4'hF; load1 = 1'b1; din1 = 4'h0;
        tick();
        load0 = 1'b0; load1 = 1'b0;
        check("casc_0f", {q1, q0}, 8'h0F);
        check("casc_rco0_at_f", rco0, 1);
        check("casc_rco1_at_0f", rco1, 0);
        enp0 = 1'b1; enp1 = 1'b1;
        tick();
        enp0 = 1'b0; enp1 = 1'b0;
        check("casc_10", {q1, q0}, 8'h10);
        load0 = 1'b1; din0 = 4'hE; load1 = 1'b1; din1 = 4'hF;
        tick();
        load0 = 1'b0; load1 = 1'b0;
        check("casc_rco1_at_fe", rco1, 0);
        enp0 = 1'b1; enp1 = 1'b1;
        tick();
        check("casc_ff", {q1, q0}, 8'hFF);
        check("casc_rco1_at_ff", rco1, 1);
        tick();
        enp0 = 1'b0; enp1 = 1'b0;
        check("casc_00", {q1, q0}, 8'h00);
        check("casc_wraps", {wrap1, wrap0}, 2'b11);

        // one-shot run to MAX_VAL=5
        os_o = 1'b1; enp_o = 1'b1; load_o = 1'b1; din_o = 4'd2;
        tick();
        load_o = 1'b0;
        check("os_loaded", {busy_o, q_o}, {1'b0, 4'd2});
        start_o = 1'b1;
        tick();
        start_o = 1'b0;
        check("os_start_busy", {busy_o, done_o, q_o}, {2'b10, 4'd2});
        tick();
        check("os_q3", {busy_o, q_o}, {1'b1, 4'd3});
        tick();
        check("os_q4", {busy_o, q_o}, {1'b1, 4'd4});
        tick();
        check("os_q5_done", {busy_o, done_o, q_o}, {2'b01, 4'd5});
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("os_hold_%0d", i), {busy_o, done_o, q_o, wrap_o}, {2'b01, 4'd5, 1'b0});
        end
        ack_o = 1'b1;
        tick();
        ack_o = 1'b0;
        check("os_ack_idle", {busy_o, done_o, q_o}, {2'b00, 4'd5});
        start_o = 1'b1;
        tick();
        start_o = 1'b0;
        check("os_start_at_max", {busy_o, done_o, q_o}, {2'b01, 4'd5});
        start_o = 1'b1; ack_o = 1'b1;
        tick();
        start_o = 1'b0; ack_o = 1'b0;
        check("os_start_ack_idle", {busy_o, done_o, q_o}, {2'b00, 4'd5});

        // asynchronous reset mid-RUN
        load_o = 1'b1; din_o = 4'd0;
        tick();
        load_o = 1'b0; start_o = 1'b1;
        tick();
        start_o = 1'b0;
        tick();
        tick();
        check("abort_pre_q2", {busy_o, q_o}, {1'b1, 4'd2});
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async", {busy_o, done_o, q_o}, {2'b00, 4'd0});
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_pending", {busy_o, done_o, q_o}, {2'b00, 4'd0});

        // oneshot dropped while RUN
        start_o = 1'b1;
        tick();
        start_o = 1'b0;
        tick();
        check("drop_run_q1", {busy_o, q_o}, {1'b1, 4'd1});
        os_o = 1'b0;
        tick();
        check("drop_idle_q2", {busy_o, done_o, q_o}, {2'b00, 4'd2});
        tick();
        tick();
        tick();
        check("drop_free_q5", {q_o, rco_o}, {4'd5, 1'b1});
        tick();
        check("drop_free_wrap", {q_o, wrap_o}, {4'd0, 1'b1});
        enp_o = 1'b0;

        // out-of-range load on MAX_VAL=9
        load_m = 1'b1; din_m = 4'd14;
        tick();
        load_m = 1'b0; enp_m = 1'b1;
        check("oor_q14", {q_m, wrap_m}, {4'd14, 1'b0});
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("oor_q_%0d", i), q_m, seq_m9[i]);
            check($sformatf("oor_wrap_%0d", i), wrap_m, i == 11);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cascade_up_counter.md
Name: cascade_up_counter

Overview:
- Registered, cascadable, synchronously loadable binary up-counter slice.
- Its count chain counts in the opposite direction to the team's existing combinational down-count and borrow next-state slice.
- Provides parallel load, synchronous clear, and a two-level enable (enp/ent) with a combinational ripple terminal-count output, so slices chain into wider counters.
- Adds a one-shot mode with a start/done/ack handshake, used for timed sequencing.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- MAX_VAL, 2**WIDTH-1, terminal count value; must be nonzero and at most 2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- sclr  input  1  synchronous clear, highest synchronous priority.
- load  input  1  synchronous parallel load of din.
- din  input  WIDTH  load value.
- enp  input  1  local count enable.
- ent  input  1  cascade enable (connect to rco of the previous slice; tie high on the LSB slice).
- oneshot  input  1  1 = one-shot mode, 0 = free-running mode.
- start  input  1  one-shot start request (single-cycle pulse).
- ack  input  1  acknowledges done.
- q  output  WIDTH  current count.
- rco  output  1  combinational ripple carry out: (q==MAX_VAL) & ent.
- wrap  output  1  registered one-cycle pulse on a MAX_VAL->0 wrap.
- busy  output  1  state==RUN.
- done  output  1  state==DONE.

Behaviour:
- Reset (rst_n low, asynchronous): q=0, wrap=0, state=IDLE, so busy=0 and done=0. rco follows q and ent combinationally during reset.
- Increment qualifier inc = enp & ent & (oneshot ? state==RUN : 1).
- Synchronous priority per rising edge:
  - sclr: q<=0, state<=IDLE, wrap<=0.
  - else load: q<=din. State is unchanged, except that a load with din==MAX_VAL while in RUN goes to DONE.
  - else inc:
    - If q==MAX_VAL: q<=0 and wrap<=1. This occurs in free-running mode only; one-shot never counts past MAX_VAL.
    - Otherwise q<=q+1 and wrap<=0.
  - else: hold q, wrap<=0.
- Arithmetic: unsigned modulo (MAX_VAL+1).
  - A loaded din greater than MAX_VAL counts upward modulo 2**WIDTH until it reaches MAX_VAL.
  - No wrap pulse is generated in that case.
- Latency: q updates on the edge after the qualifying inputs. wrap is high in the cycle immediately after q becomes 0 from MAX_VAL.
- rco has zero latency (purely combinational), so a cascade of N slices advances in a single cycle.
- FSM (evaluated only when oneshot=1; sclr overrides):
  - IDLE: start -> RUN. If q==MAX_VAL at start, go directly to DONE next edge with no count.
  - RUN:
    - An increment from MAX_VAL-1 to MAX_VAL -> DONE.
    - q holds at MAX_VAL while in DONE.
    - start is ignored in RUN.
  - DONE: done=1, held until ack -> IDLE. start is ignored; start and ack in the same cycle -> IDLE only.
  - oneshot deasserted in any state -> IDLE on the next edge. The free-running rules then apply immediately.
  - ack outside DONE: ignored.
- Simultaneous events:
  - sclr with load/start -> clear wins and state=IDLE.
  - load with inc -> load wins and no increment occurs.
  - start with load in IDLE -> both take effect.
- Reset mid-operation: immediate return to reset values. There is no pending start or done afterwards.

Test Plan:
1. Reset and free-run: WIDTH=4, MAX_VAL=15, oneshot=0, enp=ent=1 for 17 cycles after rst_n rises -> q=0,1,...,15,0,1. rco=1 only while q=15. wrap=1 only in the cycle where q=0 after 15.
2. Priority: q=7 with load=1, din=3, sclr=1 -> q=0. Next cycle load=1, din=3, enp=ent=1 -> q=3 (no increment). Hold enp=0 -> q stays 3, wrap=0.
3. Cascade: two slices with rco0->ent1, both enp=1, starting from 0x0F -> after one edge the combined value is 0x10. The upper rco asserts only at 0xFF.
4. One-shot: MAX_VAL=5, oneshot=1, load din=2, start pulse -> busy=1, q=3,4,5. Then done=1, busy=0, q holds 5 for 10 cycles. ack -> done=0, IDLE. A start at q=5 -> done=1 on the next edge with q unchanged.
5. Mid-operation abort: one-shot RUN at q=2, deassert rst_n asynchronously mid-cycle -> q=0, busy=0, done=0 immediately. Separately, oneshot dropped in RUN -> IDLE next edge and counting continues free-running.
6. Out-of-range load: MAX_VAL=9, free-run, load din=14 -> q=14,15,0,...,9. wrap stays 0 on 15->0 and pulses only on 9->0.
